pwm_apb_multi: RTL and testbench

- Parametrised successor to the single-channel APB PWM slave.
- Provides NUM_CH independent PWM channels behind one APB3 slave slot (CoreAPB3 slot 0) in the SmartFusion fabric, clocked from FAB_CLK.
- Adds a shared prescaler, double-buffered (shadowed) period/duty registers, per-channel output inversion, a centre-aligned mode, and a synchronous restart of all channels.

---
 rtl/pwm_apb_multi.sv | 216 +++++++++++++++++++++
 tb/tb_pwm_apb_multi.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_apb_multi.sv
// pwm_apb_multi -- NUM_CH independent PWM channels behind one APB3 slave.
//
// A shared prescaler produces the count tick. Each channel has buffered
// PERIOD/DUTY registers that are copied into active shadows only at load
// points, so software can update them at any time without glitching the
// current period. Channels run edge-aligned or centre-aligned, and each
// output can be inverted.
//
// Ports:
//   PCLK            fabric clock, all logic on the rising edge
//   PRESET          synchronous reset, active-high
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB3 request (only PADDR[7:0] decoded)
//   PREADY          tied 1, zero wait states
//   PSLVERR         unmapped access or write to a read-only register
//   PRDATA          combinational read data, 0 when PSEL is low
//   pwm_out         registered PWM outputs, bit n = channel n
//
// Register map (byte offsets):
//   0x00 GCTRL     bit0 global enable, bit1 sync restart (self-clearing)
//   0x04 PRESCALE
//   0x10+0x10*n    PERIOD_n buffer
//   0x14+0x10*n    DUTY_n buffer
//   0x18+0x10*n    CFG_n: bit0 enable, bit1 invert, bit2 centre mode
//   0x1C+0x10*n    COUNT_n (read-only)
module pwm_apb_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       PRDATA,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [1:0]           R_PER  = 2'd0;
  localparam logic [1:0]           R_DUTY = 2'd1;
  localparam logic [1:0]           R_CFG  = 2'd2;
  localparam logic [1:0]           R_CNT  = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

  // Global state
  logic                 gen_en;
  logic [PRE_WIDTH-1:0] prescale;
  logic [PRE_WIDTH-1:0] pre_cnt;

  // Per-channel state
  logic [CNT_WIDTH-1:0] per_b  [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_b [NUM_CH];
  logic [2:0]           cfg    [NUM_CH];
  logic [CNT_WIDTH-1:0] per_a  [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_a [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
  logic [NUM_CH-1:0]    dir_dn;
  logic [NUM_CH-1:0]    pwm_p1;

  // Decode and next-value terms
  logic [7:0]           addr;
  logic                 is_gctrl, is_pre, mapped, ro;
  logic                 wr_ok, restart, tick;
  logic [NUM_CH-1:0]    ch_hit, en_rise, mode_chg;
  logic [CNT_WIDTH-1:0] per_nx  [NUM_CH];
  logic [CNT_WIDTH-1:0] duty_nx [NUM_CH];
  logic [2:0]           cfg_nx  [NUM_CH];
  logic                 unused_bits;

  assign addr        = PADDR[7:0];
  assign unused_bits = ^{PADDR[31:8], PWDATA};
  assign PREADY      = 1'b1;

  always_comb begin
    is_gctrl = (addr == 8'h00);
    is_pre   = (addr == 8'h04);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (addr[7:4] == 4'(i + 1)) && (addr[1:0] == 2'b00);
    end
    mapped = is_gctrl | is_pre | (|ch_hit);
    ro     = (|ch_hit) && (addr[3:2] == R_CNT);
  end

  assign PSLVERR = PSEL & PENABLE & (~mapped | (PWRITE & ro));
  assign wr_ok   = PSEL & PENABLE & PWRITE & mapped & ~ro;
  assign restart = wr_ok & is_gctrl & PWDATA[1];
  // >= rather than == so that shrinking PRESCALE below the running count
  // wraps immediately instead of running the counter all the way around.
  assign tick    = gen_en & (pre_cnt >= prescale);

  // Buffer values as they will be after this edge; load points sample these
  // so a write landing on a load point is the value that gets loaded.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      per_nx[i]   = (wr_ok && ch_hit[i] && addr[3:2] == R_PER)
                    ? PWDATA[CNT_WIDTH-1:0] : per_b[i];
      duty_nx[i]  = (wr_ok && ch_hit[i] && addr[3:2] == R_DUTY)
                    ? PWDATA[CNT_WIDTH-1:0] : duty_b[i];
      cfg_nx[i]   = (wr_ok && ch_hit[i] && addr[3:2] == R_CFG)
                    ? PWDATA[2:0] : cfg[i];
      en_rise[i]  = cfg_nx[i][0] & ~cfg[i][0];
      mode_chg[i] = cfg_nx[i][2] ^ cfg[i][2];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      if (is_gctrl) PRDATA[0] = gen_en;
      if (is_pre)   PRDATA[PRE_WIDTH-1:0] = prescale;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit[i]) begin
          case (addr[3:2])
            R_PER:   PRDATA[CNT_WIDTH-1:0] = per_b[i];
            R_DUTY:  PRDATA[CNT_WIDTH-1:0] = duty_b[i];
            R_CFG:   PRDATA[2:0]           = cfg[i];
            default: PRDATA[CNT_WIDTH-1:0] = cnt[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      gen_en   <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      dir_dn   <= '0;
      pwm_p1   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per_b[i]  <= '0;
        duty_b[i] <= '0;
        cfg[i]    <= '0;
        per_a[i]  <= '0;
        duty_a[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      if (wr_ok && is_gctrl) gen_en   <= PWDATA[0];
      if (wr_ok && is_pre)   prescale <= PWDATA[PRE_WIDTH-1:0];

      if (restart || !gen_en || tick) pre_cnt <= '0;
      else                            pre_cnt <= pre_cnt + PRE_ONE;

      for (int i = 0; i < NUM_CH; i++) begin
        per_b[i]  <= per_nx[i];
        duty_b[i] <= duty_nx[i];
        cfg[i]    <= cfg_nx[i];

        if (restart || en_rise[i]) begin
          cnt[i]    <= '0;
          dir_dn[i] <= 1'b0;
          per_a[i]  <= per_nx[i];
          duty_a[i] <= duty_nx[i];
        end else if (!cfg_nx[i][0] || mode_chg[i]) begin
          cnt[i]    <= '0;
          dir_dn[i] <= 1'b0;
        end else if (tick) begin
          if (!cfg[i][2]) begin
            // Edge-aligned: 0..per_a, reload at wrap.
            if (cnt[i] >= per_a[i]) begin
              cnt[i]    <= '0;
              per_a[i]  <= per_nx[i];
              duty_a[i] <= duty_nx[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end else if (per_a[i] == '0) begin
            // Degenerate centre period: parked at 0 but still reloading so
            // a new period can be picked up.
            cnt[i]    <= '0;
            dir_dn[i] <= 1'b0;
            per_a[i]  <= per_nx[i];
            duty_a[i] <= duty_nx[i];
          end else if (!dir_dn[i]) begin
            if (cnt[i] >= per_a[i]) begin
              // Turn around; per_a == 1 turns straight back into the next
              // period, so it reloads here rather than on the way down.
              cnt[i] <= per_a[i] - CNT_ONE;
              if (per_a[i] == CNT_ONE) begin
                per_a[i]  <= per_nx[i];
                duty_a[i] <= duty_nx[i];
              end else begin
                dir_dn[i] <= 1'b1;
              end
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end else if (cnt[i] <= CNT_ONE) begin
            // Arriving at 0 ends the period: flip to up and reload, so the
            // new shadows already drive the level at cnt == 0.
            cnt[i]    <= '0;
            dir_dn[i] <= 1'b0;
            per_a[i]  <= per_nx[i];
            duty_a[i] <= duty_nx[i];
          end else begin
            cnt[i] <= cnt[i] - CNT_ONE;
          end
        end

        // ---- stage p1: registered output level ----
        pwm_p1[i] <= (cfg[i][0] && gen_en) ? ((cnt[i] < duty_a[i]) ^ cfg[i][1])
                                           : cfg[i][1];
      end
    end
  end

  assign pwm_out = pwm_p1;

endmodule

// File: tb/tb_pwm_apb_multi.sv
module tb_pwm_apb_multi;

  localparam int NUM_CH = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA;
  logic              PREADY, PSLVERR;
  logic [31:0]       PRDATA;
  logic [NUM_CH-1:0] pwm_out;

  int vectors     = 0;
  int miscompares = 0;

  pwm_apb_multi #(.NUM_CH(NUM_CH), .CNT_WIDTH(16), .PRE_WIDTH(16)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .PRDATA  (PRDATA),
    .pwm_out (pwm_out)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Finds the next rising edge of a channel and returns the lengths of the
  // high run starting there and the low run that follows (-1 on timeout).
  task automatic measure(input int ch, output int hi, output int lo);
    logic prev;
    bit   found;
    found = 1'b0;
    hi = -1; lo = -1;
    @(negedge PCLK);
    prev = pwm_out[ch];
    for (int k = 0; k < 200; k++) begin
      @(negedge PCLK);
      if (!prev && pwm_out[ch]) begin found = 1'b1; break; end
      prev = pwm_out[ch];
    end
    if (found) begin
      hi = 1;
      for (int k = 0; k < 200; k++) begin
        @(negedge PCLK);
        if (pwm_out[ch]) hi++; else break;
      end
      lo = 1;
      for (int k = 0; k < 200; k++) begin
        @(negedge PCLK);
        if (!pwm_out[ch]) lo++; else break;
      end
    end
  endtask

  task automatic const_chk(input string tag, input int ch, input logic val, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge PCLK);
      if (pwm_out[ch] !== val) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic        prev;
    bit          found;
    int          hi, lo, first, tot, maxd, dl;
    int          v [9];

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // 1. reset state
    @(negedge PCLK);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_pready", 32'(PREADY), 32'd1);
    check("rst_prdata_idle", PRDATA, 32'd0);
    rd(32'h00, d, e); check("rst_gctrl", d, 32'd0);
    rd(32'h04, d, e); check("rst_prescale", d, 32'd0);
    for (int n = 0; n < NUM_CH; n++) begin
      for (int r = 0; r < 4; r++) begin
        rd(32'h10 + 32'(16 * n + 4 * r), d, e);
        check($sformatf("rst_ch%0d_r%0d", n, r), d, 32'd0);
      end
    end

    // 2. edge mode on ch0: 3 high / 7 low
    wr(32'h04, 32'd0, e);
    wr(32'h10, 32'd9, e);
    check("wr_ok_pslverr", 32'(e), 32'd0);
    wr(32'h14, 32'd3, e);
    wr(32'h18, 32'd1, e);
    wr(32'h00, 32'd1, e);
    rd(32'h00, d, e); check("gctrl_en", d, 32'd1);
    measure(0, hi, lo);
    check("edge_hi_1", 32'(hi), 32'd3);
    check("edge_lo_1", 32'(lo), 32'd7);
    measure(0, hi, lo);
    check("edge_hi_2", 32'(hi), 32'd3);
    check("edge_lo_2", 32'(lo), 32'd7);
    rd(32'h1C, d, e);
    first = int'(d);
    check("count0_range", 32'(first < 10), 32'd1);
    for (int k = 1; k < 5; k++) begin
      rd(32'h1C, d, e);
      check($sformatf("count0_seq%0d", k), d, 32'((first + 2 * k) % 10));
    end

    // 3. shadowing: DUTY=7 committed at cnt=4 (first low cycle)
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'd7; PENABLE = 1'b0;
    found = 1'b0;
    prev = pwm_out[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (prev && !pwm_out[0]) begin found = 1'b1; break; end
      prev = pwm_out[0];
    end
    check("shadow_sync", 32'(found), 32'd1);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    measure(0, hi, lo);
    check("shadow_hi", 32'(hi), 32'd7);
    check("shadow_lo", 32'(lo), 32'd3);

    // 4. centre mode + invert on ch1: period 8, low while cnt < 2
    wr(32'h20, 32'd4, e);
    wr(32'h24, 32'd2, e);
    wr(32'h28, 32'd7, e);
    measure(1, hi, lo);
    check("centre_hi", 32'(hi), 32'd5);
    check("centre_lo", 32'(lo), 32'd3);
    wr(32'h28, 32'd6, e);
    repeat (2) @(negedge PCLK);
    const_chk("centre_disabled_inv", 1, 1'b1, 16);

    // 5. bounds on ch2
    wr(32'h30, 32'd10, e);
    wr(32'h34, 32'd0, e);
    wr(32'h38, 32'd1, e);
    repeat (2) @(negedge PCLK);
    const_chk("duty0_const0", 2, 1'b0, 25);
    wr(32'h34, 32'd20, e);
    repeat (14) @(negedge PCLK);
    const_chk("duty_gt_per_const1", 2, 1'b1, 25);
    wr(32'h04, 32'd3, e);
    rd(32'h04, d, e); check("prescale_rd", d, 32'd3);
    for (int k = 0; k < 9; k++) begin
      rd(32'h3C, d, e);
      v[k] = int'(d);
    end
    tot = 0; maxd = 0;
    for (int k = 0; k < 8; k++) begin
      dl = (v[k + 1] - v[k] + 11) % 11;
      tot += dl;
      if (dl > maxd) maxd = dl;
    end
    check("prescale3_ticks_16cyc", 32'(tot), 32'd4);
    check("prescale3_step_le1", 32'(maxd <= 1), 32'd1);

    // 6. errors and restart
    wr(32'h1C, 32'hFFFF, e);
    check("wr_ro_pslverr", 32'(e), 32'd1);
    rd(32'h10, d, e); check("ro_wr_per0_kept", d, 32'd9);
    rd(32'h14, d, e); check("ro_wr_duty0_kept", d, 32'd7);
    rd(32'h18, d, e); check("ro_wr_cfg0_kept", d, 32'd1);
    rd(32'h10 + 32'(16 * NUM_CH), d, e);
    check("rd_unmapped_pslverr", 32'(e), 32'd1);
    check("rd_unmapped_data", d, 32'd0);
    wr(32'h10 + 32'(16 * NUM_CH), 32'd5, e);
    check("wr_unmapped_pslverr", 32'(e), 32'd1);
    rd(32'h04, d, e); check("unmapped_wr_prescale_kept", d, 32'd3);
    wr(32'h00, 32'd3, e);
    rd(32'h1C, d, e); check("restart_count0", d, 32'd0);
    wr(32'h00, 32'd3, e);
    rd(32'h3C, d, e); check("restart_count2", d, 32'd0);
    rd(32'h00, d, e); check("restart_gctrl_rd", d, 32'd1);

    // mid-operation reset with an inverted idle channel
    @(negedge PCLK);
    check("pre_reset_inv_idle", 32'(pwm_out[1]), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    rd(32'h28, d, e); check("midrst_cfg1", d, 32'd0);
    rd(32'h00, d, e); check("midrst_gctrl", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
